// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the parametrised priority encoder family.
package prio_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2 for tools without $clog2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational find-first-set starting at an arbitrary position, wrapping
// around the end of the request vector.
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter int N = 16,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         none
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;
    int             sel;

    assign dbl = {req, req};

    // Keep only the N-bit window beginning at start, so wrapped requests
    // appear in the upper copy and an ordinary lowest-bit search suffices.
    always_comb begin
        masked = '0;
        for (int j = 0; j < 2 * N; j++) begin
            masked[j] = dbl[j] && (j >= int'(start)) && (j < int'(start) + N);
        end
    end

    always_comb begin
        sel = 0;
        for (int j = 2 * N - 1; j >= 0; j--) begin
            if (masked[j]) begin
                sel = j;
            end
        end
    end

    assign idx  = (sel >= N) ? W'(sel - N) : W'(sel);
    assign none = ~|req;

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-way priority encoder with fixed or round-robin priority,
// no-request flag and population count, behind a valid/ready handshake.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter int N = 16,
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] req,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_none,
    output logic [W:0]   out_count
);

    logic         accept;
    logic [W-1:0] ptr;
    logic [W-1:0] start;
    logic [W-1:0] pick_idx;
    logic [W-1:0] ptr_next;
    logic         pick_none;
    logic [W:0]   count;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Fixed priority is simply a search that always starts at bit 0.
    assign start = (mode == MODE_RR) ? ptr : '0;

    prio_pick #(.N(N)) u_pick (
        .req   (req),
        .start (start),
        .idx   (pick_idx),
        .none  (pick_none)
    );

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + (W + 1)'(req[i]);
        end
    end

    // Explicit wrap so non-power-of-two N returns to 0 after winner N-1.
    assign ptr_next = (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_none  <= 1'b0;
            out_count <= '0;
            ptr       <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_idx   <= pick_idx;
                out_none  <= pick_none;
                out_count <= count;
                if (mode == MODE_RR && !pick_none) begin
                    ptr <= ptr_next;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised successor of the team's fixed 16-to-4 priority encoder.
- Encodes an N-bit request vector to a binary index. Priority is either fixed (lowest index wins) or round-robin (rotating start pointer), selectable per transaction.
- Result is registered behind a valid/ready handshake so it can sit in pipelined arbitration and interrupt paths.
- Also reports a no-request flag and the population count of the accepted vector.

Parameters:
- N, 16, request vector width; legal range 2..256, need not be a power of two.
- W, $clog2(N), index width; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  req/mode are presented.
- in_ready  output  1  block can accept this cycle.
- req  input  N  request vector; bit i = requester i.
- mode  input  1  0 = fixed priority, 1 = round-robin; sampled with req.
- out_valid  output  1  registered result is available.
- out_ready  input  1  consumer takes the result.
- out_idx  output  W  encoded winner index.
- out_none  output  1  accepted vector was all zeros.
- out_count  output  W+1  number of set bits in the accepted vector.

Behaviour:
- Reset: applies on any clk edge with rst=1.
  - out_valid=0, out_idx=0, out_none=0, out_count=0, internal pointer ptr=0.
  - A result held at reset time is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational and has no dependence on in_valid.
  - Accept when in_valid && in_ready; the result appears on the next edge (latency 1).
  - Full throughput: one result per cycle while out_ready=1.
  - While out_valid && !out_ready, out_idx, out_none and out_count hold stable and ptr does not change.
- Fixed mode (mode=0): out_idx = lowest i with req[i]=1. This is identical to the legacy 16:4 encoder when N=16.
- Round-robin mode (mode=1):
  - out_idx = first i with req[i]=1, searching ptr, ptr+1, ..., N-1, then 0, ..., ptr-1.
  - After an accepted non-zero vector, ptr <= (out_idx+1) mod N.
  - Wrap: winner N-1 sets ptr to 0, including when N is not a power of two.
- Fixed-mode accepts do not modify ptr. Switching modes retains ptr.
- All-zero vector accepted:
  - out_valid=1, out_none=1, out_idx=0, out_count=0.
  - ptr unchanged in both modes.
- Non-zero vector accepted: out_none=0, out_count = popcount(req), range 1..N.
- Single-bit request: both modes return that bit's index.
- in_valid=0 with out_ready=1: out_valid falls to 0 on the next edge. Outputs keep their last values but are don't-care.
- Simultaneous out_ready and new accept: the old result is consumed and the new one loaded on the same edge, with no bubble.
- No state exists beyond the output register and ptr. No multi-cycle search: the whole search is single-cycle combinational.

Decomposition:
- Shared package prio_enc_pkg holds:
  - constants MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - a function clog2 for tools lacking $clog2.
- One natural sub-module, prio_pick (combinational, parameter N):
  - inputs req and start (W bits); outputs idx and none;
  - implemented as a double-width masked find-first.
- Fixed mode reuses prio_pick with start=0.
- Popcount stays inline in the top level.

Test Plan (N=16 unless stated):
1. Reset then fixed mode, req=16'h8010, out_ready=1 -> next cycle out_valid=1, out_idx=4, out_count=2, out_none=0; ptr stays 0.
2. Round-robin, req=16'hFFFF held for 17 accepts with out_ready=1 -> out_idx sequence 0, 1, ..., 15, 0 (wrap).
3. Round-robin, ptr set to 5 by a prior win at idx 4, then req=16'h0011 -> out_idx=0 (wrapped search), ptr becomes 1.
4. req=0 accepted in either mode -> out_none=1, out_idx=0, out_count=0; a following RR req=16'h0003 still yields idx per the unchanged ptr.
5. Backpressure: out_ready=0 for 3 cycles after a result of idx=7 -> in_ready=0, outputs stable at 7, ptr frozen. Then assert out_ready with a new in_valid -> the new result loads on the same edge.
6. N=5: RR with req=5'b11111 over 6 accepts gives 0,1,2,3,4,0. Then assert rst mid-stream -> out_valid=0, and the next RR accept of 5'b11111 yields idx 0.
